amber128_cap_wb_ctrl: RTL and testbench

Writeback controller for the 1W/3R capability register file. It shares the file's single write port between NUM_REQ producers (e.g. cap ALU, load unit, trap unit) using round-robin arbitration and drives the file's we/waddr/wdata from a registered output stage. It also keeps a per-register busy scoreboard: issue reserves a destination, the committed write releases it, and busy_o tells issue when a source is safe to read.

---
 rtl/amber128_cap_wb_ctrl.sv | 110 +++++++++++
 tb/tb_amber128_cap_wb_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amber128_cap_wb_ctrl.sv
// Writeback controller for the 1W/3R capability register file: round-robin write-port arbiter,
// registered capfile write stage and per-register busy scoreboard.
package amber128_cap_pkg;
  localparam int CAP_REG_AW = 5;
  localparam int C_XLEN     = 128;
endpackage

module amber128_cap_wb_ctrl
  import amber128_cap_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int AW        = CAP_REG_AW,
  parameter int XLEN      = C_XLEN,
  parameter int REG_COUNT = 2**AW
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*AW-1:0]   req_addr_i,
  input  logic [NUM_REQ*XLEN-1:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic                    rsv_valid_i,
  input  logic [AW-1:0]           rsv_addr_i,
  output logic                    rsv_ready_o,
  input  logic                    flush_i,
  output logic [REG_COUNT-1:0]    busy_o,
  output logic                    cap_we_o,
  output logic [AW-1:0]           cap_waddr_o,
  output logic [XLEN-1:0]         cap_wdata_o,
  output logic                    wb_err_o
);

  localparam int RRW = $clog2(NUM_REQ);

  logic [RRW-1:0]       rr_q, rr_d;
  logic [RRW-1:0]       win_idx;
  logic                 win_found;
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic                 cap_we_q;
  logic [AW-1:0]        cap_waddr_q, cap_waddr_d;
  logic [XLEN-1:0]      cap_wdata_q, cap_wdata_d;
  logic                 wb_err_q, wb_err_d;

  // Round-robin search starting at rr_q; any valid request is granted this cycle.
  always_comb begin
    // NOTE: every variable gets a default first so the combinational block never infers a latch.
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!win_found && req_valid_i[idx]) begin
        win_found = 1'b1;
        win_idx   = RRW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    rr_d        = rr_q;
    cap_waddr_d = cap_waddr_q;
    cap_wdata_d = cap_wdata_q;
    if (win_found) begin
      req_ready_o[win_idx] = 1'b1;
      rr_d        = RRW'((int'(win_idx) + 1) % NUM_REQ);
      cap_waddr_d = req_addr_i[int'(win_idx)*AW +: AW];
      cap_wdata_d = req_data_i[int'(win_idx)*XLEN +: XLEN];
    end
  end

  // A reservation colliding with the write being committed this cycle is refused as well.
  assign rsv_ready_o = rsv_valid_i & ~busy_q[rsv_addr_i] & ~flush_i
                     & ~(cap_we_q && (cap_waddr_q == rsv_addr_i));

  always_comb begin
    busy_d = busy_q;
    if (cap_we_q)    busy_d[cap_waddr_q] = 1'b0;
    if (rsv_ready_o) busy_d[rsv_addr_i]  = 1'b1;
    if (flush_i)     busy_d              = '0;
  end

  assign wb_err_d = cap_we_q & ~busy_q[cap_waddr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      busy_q      <= '0;
      cap_we_q    <= 1'b0;
      cap_waddr_q <= '0;
      cap_wdata_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      cap_we_q    <= win_found;
      cap_waddr_q <= cap_waddr_d;
      cap_wdata_q <= cap_wdata_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign busy_o      = busy_q;
  assign cap_we_o    = cap_we_q;
  assign cap_waddr_o = cap_waddr_q;
  assign cap_wdata_o = cap_wdata_q;
  assign wb_err_o    = wb_err_q;

endmodule

// File: tb/tb_amber128_cap_wb_ctrl.sv
// Self-checking bench for amber128_cap_wb_ctrl: behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_amber128_cap_wb_ctrl;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int XL = 128;
  localparam int RC = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr  = '0;
  logic [N*XL-1:0]   req_data  = '0;
  logic [N-1:0]      req_ready;
  logic              rsv_valid = 1'b0;
  logic [AW-1:0]     rsv_addr  = '0;
  logic              rsv_ready;
  logic              flush = 1'b0;
  logic [RC-1:0]     busy;
  logic              cap_we;
  logic [AW-1:0]     cap_waddr;
  logic [XL-1:0]     cap_wdata;
  logic              wb_err;

  int checks = 0;
  int errors = 0;

  amber128_cap_wb_ctrl #(.NUM_REQ(N), .AW(AW), .XLEN(XL), .REG_COUNT(RC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
    .flush_i(flush), .busy_o(busy),
    .cap_we_o(cap_we), .cap_waddr_o(cap_waddr), .cap_wdata_o(cap_wdata),
    .wb_err_o(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_rr    = 0;
  bit [RC-1:0]   m_busy  = '0;
  bit            m_we    = 1'b0;
  bit [AW-1:0]   m_waddr = '0;
  bit [XL-1:0]   m_wdata = '0;
  bit            m_err   = 1'b0;

  function automatic int m_winner();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (req_valid[k] === 1'b1) return k;
    end
    return -1;
  endfunction

  function automatic logic m_rsv_ok();
    return rsv_valid && !m_busy[rsv_addr] && !flush && !(m_we && m_waddr == rsv_addr);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rr = 0; m_busy = '0; m_we = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
    end else begin
      int          w;
      bit [RC-1:0] nb;
      w  = m_winner();
      nb = m_busy;
      if (m_we) nb[m_waddr] = 1'b0;
      if (m_rsv_ok()) nb[rsv_addr] = 1'b1;
      if (flush) nb = '0;
      m_err = m_we && !m_busy[m_waddr];
      if (w >= 0) begin
        m_we    = 1'b1;
        m_waddr = req_addr[w*AW +: AW];
        m_wdata = req_data[w*XL +: XL];
        m_rr    = (w + 1) % N;
      end else begin
        m_we = 1'b0;
      end
      m_busy = nb;
    end
  end

  // Compare process: outputs are meaningful on every cycle.
  always @(negedge clk) begin
    int w;
    w = m_winner();
    check("m_req_ready", req_ready, (w < 0) ? '0 : (XL'(1) << w));
    check("m_rsv_ready", rsv_ready, m_rsv_ok());
    check("m_busy", busy, m_busy);
    check("m_cap_we", cap_we, m_we);
    check("m_cap_waddr", cap_waddr, m_waddr);
    check("m_cap_wdata", cap_wdata, m_wdata);
    check("m_wb_err", wb_err, m_err);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [XL-1:0] d);
    req_valid[k]        = v;
    req_addr[k*AW +: AW] = a;
    req_data[k*XL +: XL] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0]  rr_grant [6];
    logic [AW-1:0] rr_addr  [6];
    rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_addr  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

    // Reset with all requesters valid
    #1 rst = 1'b1;
    set_req(0, 1, 5'd1, 128'h101);
    set_req(1, 1, 5'd2, 128'h102);
    set_req(2, 1, 5'd3, 128'h103);
    #20;
    check("rst_cap_we", cap_we, 0);
    check("rst_busy", busy, 0);
    check("rst_wdata", cap_wdata, 0);
    check("rst_grant", req_ready, 3'b001);
    req_valid = '0;
    step();
    rst = 1'b0;

    // Pre-reserve r1..r3
    for (int r = 1; r <= 3; r++) begin
      rsv_valid = 1'b1; rsv_addr = AW'(r);
      #5 check("pre_rsv_ready", rsv_ready, 1);
      step();
    end
    rsv_valid = 1'b0;
    check("pre_busy", busy, 32'h0000_000E);

    // Round-robin: grants 0,1,2,0,1,2; registers re-reserved once their first write commits
    for (int i = 0; i <= 6; i++) begin
      req_valid = (i < 6) ? 3'b111 : 3'b000;
      rsv_valid = (i >= 2 && i <= 4);
      rsv_addr  = AW'(i - 1);
      #5;
      if (i < 6) check("rr_grant", req_ready, rr_grant[i]);
      if (i >= 1) begin
        check("rr_cap_we", cap_we, 1);
        check("rr_waddr", cap_waddr, rr_addr[i-1]);
      end
      check("rr_no_err", wb_err, 0);
      step();
    end
    rsv_valid = 1'b0;
    #5 check("rr_busy_clear", busy, 0);
    check("rr_no_err_tail", wb_err, 0);
    step();

    // Scoreboard: reserve r5, refuse repeat, commit, re-reserve
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    #5 check("sb_rsv1", rsv_ready, 1);
    step();
    check("sb_busy5_set", busy[5], 1);
    set_req(1, 1, 5'd5, {16{8'hA5}});
    #5 check("sb_rsv_refused", rsv_ready, 0);
    check("sb_grant1", req_ready, 3'b010);
    step();
    rsv_valid = 1'b0; req_valid = '0;
    #5 check("sb_we", cap_we, 1);
    check("sb_waddr", cap_waddr, 5);
    check("sb_wdata", cap_wdata, {16{8'hA5}});
    check("sb_busy5_still", busy[5], 1);
    step();
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    #5 check("sb_busy5_clear", busy[5], 0);
    check("sb_no_err", wb_err, 0);
    check("sb_rerserve", rsv_ready, 1);
    step();
    rsv_valid = 1'b0;
    #5 check("sb_busy5_again", busy[5], 1);
    step();

    // Same-cycle collision: commit r7 while reserving r7 then r8
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_valid = 1'b0;
    set_req(0, 1, 5'd7, 128'h7777);
    #5 check("col_grant0", req_ready, 3'b001);
    step();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #5 check("col_we_r7", cap_waddr, 7);
    check("col_rsv7_refused", rsv_ready, 0);
    rsv_addr = 5'd8;
    #1 check("col_rsv8_ok", rsv_ready, 1);
    step();
    rsv_valid = 1'b0;
    #5 check("col_busy8", busy[8], 1);
    check("col_busy7", busy[7], 0);
    check("col_no_err", wb_err, 0);
    step();

    // Error: write to non-reserved r9
    set_req(2, 1, 5'd9, 128'h9999);
    #5 check("err_grant2", req_ready, 3'b100);
    step();
    req_valid = '0;
    #5 check("err_we", cap_we, 1);
    check("err_waddr", cap_waddr, 9);
    check("err_not_yet", wb_err, 0);
    step();
    #5 check("err_pulse", wb_err, 1);
    step();
    #5 check("err_pulse_end", wb_err, 0);
    step();

    // Flush: busy r2,r4; flush with reserve r6 and a grant to r4
    rsv_valid = 1'b1; rsv_addr = 5'd2;
    step();
    rsv_addr = 5'd4;
    step();
    rsv_addr = 5'd6; flush = 1'b1;
    set_req(0, 1, 5'd4, 128'h4444);
    #5 check("fl_busy_pre", busy & 32'h0000_0014, 32'h0000_0014);
    check("fl_rsv_dropped", rsv_ready, 0);
    check("fl_grant", req_ready, 3'b001);
    step();
    flush = 1'b0; rsv_valid = 1'b0; req_valid = '0;
    #5 check("fl_busy_zero", busy, 0);
    check("fl_we_r4", cap_we, 1);
    check("fl_waddr", cap_waddr, 4);
    step();
    #5 check("fl_err", wb_err, 1);
    check("fl_busy_zero2", busy, 0);
    step();

    // Reset mid-operation discards the in-flight write
    set_req(1, 1, 5'd3, 128'h3333);
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    step();
    req_valid = '0; rsv_valid = 1'b0;
    #5 check("mr_we_before", cap_we, 1);
    check("mr_busy10", busy[10], 1);
    rst = 1'b1;
    #1 check("mr_we_killed", cap_we, 0);
    check("mr_busy_cleared", busy, 0);
    step();
    rst = 1'b0;
    set_req(2, 1, 5'd11, 128'hB);
    #5 check("mr_rr_zero", req_ready, 3'b100);
    step();
    req_valid = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
